// File: rtl/reg_snapshot.sv
// Register-file snapshot engine: stalls the CPU while copying all N registers
// into a local buffer, then streams them out as (addr, data) beats.
module reg_snapshot #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  cpu_stall,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_last,
   output logic                  done
);

   localparam int                    N        = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
   localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STREAM  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] snap_q [N];
   logic                  idx_at_last;
   logic                  handshake;

   assign idx_at_last = (idx_q == LAST_IDX);
   assign handshake   = out_valid && out_ready;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // NOTE: the buffer is a plain storage array with no reset; every entry is
   // rewritten by a complete capture before it can ever be streamed.
   always_ff @(posedge clk) begin
      if (state_q == CAPTURE) begin
         snap_q[idx_q] <= rdata;
      end
   end

   // NOTE: defaults at the top of each always_comb keep it latch-free.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = CAPTURE;
               idx_d   = '0;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (idx_at_last) begin
               state_d = STREAM;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         STREAM: begin
            // Abort wins over a simultaneous final handshake: no done pulse.
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (handshake) begin
               if (idx_at_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      raddr     = '0;
      cpu_stall = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_addr  = '0;
      out_last  = 1'b0;
      case (state_q)
         CAPTURE: begin
            raddr     = idx_q;
            cpu_stall = 1'b1;
         end
         STREAM: begin
            out_valid = 1'b1;
            out_data  = snap_q[idx_q];
            out_addr  = idx_q;
            out_last  = idx_at_last;
         end
         default: begin
         end
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: doc/reg_snapshot.md
REG_SNAPSHOT -- requirements
Module: reg_snapshot

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 2, meaning the register address width; N = 2**ADDR_WIDTH registers.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, meaning the register data width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 The module SHALL have port start, input, 1 bit: snapshot request, sampled only in IDLE.
REQ-006 The module SHALL have port abort, input, 1 bit: cancels any snapshot in progress.
REQ-007 The module SHALL have port raddr, output, ADDR_WIDTH bits: read address driven to the register-file read port.
REQ-008 The module SHALL have port rdata, input, DATA_WIDTH bits: combinational read data returned for raddr in the same cycle.
REQ-009 The module SHALL have port cpu_stall, output, 1 bit: holds the processor (no register writes) while high.
REQ-010 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a stream beat is available.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-013 The module SHALL have port out_data, output, DATA_WIDTH bits: the captured register value.
REQ-014 The module SHALL have port out_addr, output, ADDR_WIDTH bits: the register index of out_data.
REQ-015 The module SHALL have port out_last, output, 1 bit: high when out_addr == N-1 and out_valid is high.
REQ-016 The module SHALL have port done, output, 1 bit: one-cycle pulse when a snapshot completes normally.

Function
REQ-017 The module SHALL implement an FSM with states IDLE, CAPTURE and STREAM, plus an ADDR_WIDTH-bit index counter idx and an N x DATA_WIDTH capture buffer.
REQ-018 In IDLE, with start=1 and abort=0, the module SHALL go to CAPTURE with idx=0; otherwise it SHALL stay in IDLE.
REQ-019 In CAPTURE, the module SHALL hold raddr=idx and cpu_stall=1, and each cycle SHALL write buf[idx] <= rdata.
REQ-020 In CAPTURE, idx SHALL increment each cycle; on the cycle idx==N-1 the module SHALL go to STREAM with idx=0, so CAPTURE lasts exactly N cycles.
REQ-021 In STREAM, the module SHALL hold cpu_stall=0, out_valid=1, out_data=buf[idx] and out_addr=idx.
REQ-022 On out_valid & out_ready with idx < N-1, idx SHALL increment; the module SHALL remain in STREAM.
REQ-023 On out_valid & out_ready with idx == N-1, the module SHALL go to IDLE and assert done in the following cycle only.
REQ-024 While out_ready=0, out_data, out_addr and out_last SHALL hold stable, and out_valid SHALL stay high.
REQ-025 Outside STREAM, out_valid and out_last SHALL be 0, and out_data and out_addr SHALL be 0.
REQ-026 Outside CAPTURE, raddr SHALL be 0 and cpu_stall SHALL be 0.
REQ-027 start asserted while busy=1 SHALL be ignored, not queued.
REQ-028 abort=1 in CAPTURE or STREAM SHALL force IDLE at the next edge, with no done pulse; abort takes priority over a simultaneous final handshake.
REQ-029 abort=1 together with start=1 in IDLE SHALL leave the module in IDLE.
REQ-030 Buffer contents SHALL persist across abort; a new snapshot SHALL overwrite all N entries before any of them is streamed.
REQ-031 Latency: start sampled at edge t SHALL give cpu_stall=1 for cycles t+1..t+N and out_valid=1 from cycle t+N+1.

Reset
REQ-032 reset=0 at a clk edge SHALL put the module in IDLE with idx=0, and busy, cpu_stall, out_valid, out_last, done, raddr, out_data and out_addr all 0.
REQ-033 Reset SHALL take priority over start and abort, and SHALL cancel a snapshot mid-operation without a done pulse; buffer contents need not be cleared.

Verification
REQ-034 The bench SHALL run the basic snapshot with N=4: registers {0x11,0x22,0x33,0x44}, start pulse, out_ready=1 -> cpu_stall high exactly 4 cycles, raddr 0,1,2,3; beats (0,0x11),(1,0x22),(2,0x33),(3,0x44) on consecutive cycles, out_last on beat 3, done one cycle after it.
REQ-035 The bench SHALL check backpressure: out_ready=0 for 3 cycles at beat 1 -> out_data=0x22, out_addr=1 held stable, no beat lost or duplicated, done after beat 3.
REQ-036 The bench SHALL check abort: abort during CAPTURE at idx=2 -> IDLE next cycle, cpu_stall=0, no out_valid, no done; a following start yields a full correct snapshot.
REQ-037 The bench SHALL check abort on the last beat: abort=1 with the handshake at idx=3 -> IDLE, done stays 0.
REQ-038 The bench SHALL check start while busy: a start pulse during STREAM -> no effect; exactly 4 beats, one done.
REQ-039 The bench SHALL check reset mid-stream: reset=0 at beat 2 -> all outputs 0 at the next edge; after release, IDLE until start.
